// File: rtl/adder_rr_arbiter.sv
// Four requesters share one 32-bit Kogge-Stone adder through a round-robin
// arbiter feeding a single-entry result register with valid/ready drain.

module ks_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  // bit 0 of each level carries cin as a pure generate term
  logic [6:0][32:0] g;
  logic [6:0][32:0] p;

  always_comb begin
    g = '0;
    p = '0;
    g[0] = {a & b, cin};
    p[0] = {a ^ b, 1'b0};
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 33; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    sum  = p[0][32:1] ^ g[6][31:0];
    cout = g[6][32];
  end
endmodule

module adder_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]            req_sub,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf,
  output logic [1:0]                 rsp_id
);
  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       id_q, id_d;

  logic             found;
  logic [1:0]       gnt;
  logic [1:0]       idx;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;

  // descending scan so the index closest to ptr is written last and wins
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    idx   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign accept    = (state_q == EMPTY) | rsp_ready;
  assign xfer      = found & accept & rst_n;
  assign req_ready = xfer ? (NREQ'(1) << gnt) : '0;

  assign op_a   = req_a[gnt];
  assign op_b   = req_b[gnt] ^ {WIDTH{req_sub[gnt]}};
  assign op_cin = req_sub[gnt];

  ks_adder32 u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                   (add_sum[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    if (xfer) begin
      state_d = FULL;
      ptr_d   = gnt + 2'd1;
      sum_d   = add_sum;
      cout_d  = add_cout;
      ovf_d   = add_ovf;
      id_d    = gnt;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: directed corner cases, then random traffic
// scored against an arithmetic reference of the shared adder slot.

module tb_adder_rr_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_a;
  logic [3:0][31:0] req_b;
  logic [3:0]       req_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;
  logic [1:0]       rsp_id;

  adder_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int last_g  = -1;

  bit          m_full;
  logic [31:0] m_sum;
  bit          m_cout;
  bit          m_ovf;
  int          m_id;
  int          m_last;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0;
    m_sum  = '0;
    m_cout = 0;
    m_ovf  = 0;
    m_id   = 0;
    m_last = 3;
  endtask

  function automatic int winner();
    for (int k = 1; k <= 4; k++)
      if (req_valid[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic calc(input int g);
    logic [31:0] a, b;
    logic [32:0] u;
    longint sa, sb, s;
    a  = req_a[g];
    b  = req_b[g];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (req_sub[g]) begin
      m_sum  = a - b;
      m_cout = (a >= b);
      s      = sa - sb;
    end else begin
      u      = {1'b0, a} + {1'b0, b};
      m_sum  = u[31:0];
      m_cout = u[32];
      s      = sa + sb;
    end
    m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic step();
    int g;
    bit acc;
    logic [3:0] exp_rdy;
    #1;
    g       = winner();
    acc     = !m_full || rsp_ready;
    exp_rdy = (acc && g >= 0) ? (4'b0001 << g) : 4'b0000;
    check("req_ready", req_ready, exp_rdy);
    last_g = -1;
    if (acc && g >= 0) begin
      calc(g);
      m_full = 1;
      m_id   = g;
      m_last = g;
      last_g = g;
      n_xfer++;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", rsp_valid, m_full);
    if (m_full) begin
      check("rsp_sum", rsp_sum, m_sum);
      check("rsp_cout", rsp_cout, m_cout);
      check("rsp_ovf", rsp_ovf, m_ovf);
      check("rsp_id", rsp_id, m_id);
    end
  endtask

  task automatic set_req(input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
    req_a[r]   = a;
    req_b[r]   = b;
    req_sub[r] = s;
  endtask

  task automatic reset_checks();
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_cout", rsp_cout, 0);
    check("rst_ovf", rsp_ovf, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready", req_ready, 0);
  endtask

  task automatic release_reset();
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] held;
  int cyc;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    model_reset();
    #12;
    reset_checks();
    release_reset();

    // single add with wrap and carry
    rsp_ready = 1'b1;
    set_req(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 4'b0100;
    step();
    check("add_valid", rsp_valid, 1);
    check("add_sum", rsp_sum, 32'h0);
    check("add_cout", rsp_cout, 1);
    check("add_ovf", rsp_ovf, 0);
    check("add_id", rsp_id, 2);
    req_valid = 4'b0000;
    step();

    // subtract with signed overflow
    set_req(0, 32'h8000_0000, 32'h0000_0001, 1'b1);
    req_valid = 4'b0001;
    step();
    check("sub_sum", rsp_sum, 32'h7FFF_FFFF);
    check("sub_cout", rsp_cout, 1);
    check("sub_ovf", rsp_ovf, 1);
    check("sub_id", rsp_id, 0);
    req_valid = 4'b0000;
    step();

    // round-robin from reset
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_checks();
    release_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 4; r++) set_req(r, $urandom, $urandom, 1'($urandom));
      step();
      check("rr_id", rsp_id, k % 4);
    end

    // backpressure
    req_valid = 4'b0000;
    step();
    rsp_ready = 1'b0;
    set_req(1, 32'd100, 32'd23, 1'b0);
    req_valid = 4'b0010;
    step();
    held = rsp_sum;
    check("bp_first", held, 32'd123);
    set_req(1, 32'd5, 32'd3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ready", req_ready, 0);
      check("bp_hold", rsp_sum, held);
      check("bp_id", rsp_id, 1);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_drain_id", rsp_id, 1);
    check("bp_drain_sum", rsp_sum, 32'd2);

    // async reset while holding a result
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    step();
    check("ar_full", rsp_valid, 1);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1001;
    model_reset();
    #1;
    reset_checks();
    release_reset();
    set_req(0, 32'd7, 32'd8, 1'b0);
    set_req(3, 32'd9, 32'd1, 1'b0);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    step();
    check("ar_first_id", rsp_id, 0);
    check("ar_first_sum", rsp_sum, 32'd15);

    // random regression
    req_valid = 4'b0000;
    step();
    n_xfer = 0;
    last_g = -1;
    cyc    = 0;
    while (n_xfer < 10000 && cyc < 40000) begin
      for (int r = 0; r < 4; r++) begin
        if (!(req_valid[r] && r != last_g)) begin
          req_valid[r] = ($urandom_range(0, 2) != 0);
          set_req(r, rnd_op(), rnd_op(), 1'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    check("xfer_budget", (n_xfer >= 10000), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
